// File: rtl/double_sqrt_stream.sv
// Stream wrapper around the free-running double_sqrt pipeline:
// credit-controlled valid/ready in, FWFT result FIFO out.
module double_sqrt_stream #(
  parameter int LATENCY    = 20,
  parameter int FIFO_DEPTH = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [63:0] sqrt_a,
  input  logic [63:0] sqrt_z,
  output logic [63:0] out_data,
  output logic        out_invalid,
  output logic        out_valid,
  input  logic        out_ready
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 2;
  localparam logic [CW-1:0] DEPTH = CW'(FIFO_DEPTH);

  logic               a_vld;
  logic               a_inv;
  logic [LATENCY-1:0] vpipe;
  logic [LATENCY-1:0] fpipe;
  logic [CW-1:0]      inflight;
  logic [CW-1:0]      count;
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [64:0]        mem [FIFO_DEPTH];

  logic accept;
  logic wr;
  logic rd;
  logic inv;

  assign inv = (in_data[63] && in_data[62:0] != '0)
            || (in_data[62:52] == 11'h7FF
                && in_data[51:0] != '0);

  assign in_ready  = rst_n && ((count + inflight) != DEPTH);
  assign accept    = in_valid && in_ready;
  assign wr        = vpipe[LATENCY-1];
  assign out_valid = (count != '0);
  assign rd        = out_valid && out_ready;

  assign out_data    = mem[rd_ptr][63:0];
  assign out_invalid = mem[rd_ptr][64];

  // a_vld/a_inv tag the operand while it sits on sqrt_a;
  // vpipe then follows it through the LATENCY sqrt stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sqrt_a <= '0;
      a_vld  <= 1'b0;
      a_inv  <= 1'b0;
      vpipe  <= '0;
      fpipe  <= '0;
    end else begin
      sqrt_a <= accept ? in_data : 64'h0;
      a_vld  <= accept;
      a_inv  <= accept && inv;
      vpipe  <= {vpipe[LATENCY-2:0], a_vld};
      fpipe  <= {fpipe[LATENCY-2:0], a_inv};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= '0;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      inflight <= inflight + CW'(accept) - CW'(wr);
      count    <= count + CW'(wr) - CW'(rd);
      if (wr)
        wr_ptr <= wr_ptr + AW'(1);
      if (rd)
        rd_ptr <= rd_ptr + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr)
      mem[wr_ptr] <= {fpipe[LATENCY-1], sqrt_z};
  end

  a_no_overflow : assert property (
    @(posedge clk) disable iff (!rst_n)
    wr |-> (count < DEPTH)
  );

endmodule

// File: tb/tb_double_sqrt_stream.sv
// Bench for double_sqrt_stream: behavioural sqrt pipe,
// directed vector table, bursts, backpressure, reset.
module tb_double_sqrt_stream;

  localparam int LAT   = 20;
  localparam int DEPTH = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] sqrt_a;
  logic [63:0] sqrt_z;
  logic [63:0] out_data;
  logic        out_invalid;
  logic        out_valid;
  logic        out_ready = 1'b0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  double_sqrt_stream #(.LATENCY(LAT), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready),
    .sqrt_a(sqrt_a), .sqrt_z(sqrt_z),
    .out_data(out_data), .out_invalid(out_invalid),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  function automatic logic [63:0] root(input logic [63:0] x);
    return $realtobits($sqrt($bitstoreal(x)));
  endfunction

  function automatic logic inv_of(input logic [63:0] x);
    logic nan;
    nan = (x[62:52] == 11'h7FF) && (x[51:0] != 0);
    return nan || ($bitstoreal(x) < 0.0);
  endfunction

  // Free-running double_sqrt model, LAT clocks from a to z.
  logic [63:0] zp [LAT];
  initial for (int i = 0; i < LAT; i++) zp[i] = '0;
  always @(posedge clk) begin
    zp[0] <= root(sqrt_a);
    for (int i = 1; i < LAT; i++) zp[i] <= zp[i-1];
  end
  assign sqrt_z = zp[LAT-1];

  typedef struct {
    logic [63:0] d;
    logic        inv;
  } res_t;

  res_t q[$];
  res_t e;
  int   cyc = 0;
  int   pops = 0;
  int   accepts = 0;
  int   pop_cyc[$];

  // Scoreboard: push on accept, compare on pop.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      q.delete();
    end else begin
      if (out_valid && out_ready) begin
        tests++;
        pops++;
        pop_cyc.push_back(cyc);
        if (q.size() == 0) begin
          fails++;
          $display("FAIL pop_order: pop %h with nothing expected",
                   out_data);
        end else begin
          e = q.pop_front();
          if (out_invalid !== e.inv
              || (!e.inv && out_data !== e.d)) begin
            fails++;
            $display("FAIL pop_order: got %h/%b, expected %h/%b",
                     out_data, out_invalid, e.d, e.inv);
          end
        end
      end
      if (in_valid && in_ready) begin
        e.d   = root(in_data);
        e.inv = inv_of(in_data);
        q.push_back(e);
        accepts++;
      end
    end
  end

  task automatic check(input string name,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] rnd_pos();
    return {1'b0, 11'($urandom_range(1, 2046)),
            20'($urandom), 32'($urandom)};
  endfunction

  function automatic logic [63:0] rnd_any();
    logic [63:0] x;
    x = rnd_pos();
    case ($urandom_range(0, 7))
      0: x[63] = 1'b1;
      1: x = 64'h7FF8_0000_0000_0001;
      2: x = 64'h8000_0000_0000_0000;
      3: x = 64'h7FF0_0000_0000_0000;
      default: ;
    endcase
    return x;
  endfunction

  task automatic single(input logic [63:0] x, output int lat);
    in_data  = x;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    lat = 0;
    for (int k = 1; k <= 60; k++) begin
      step();
      if (out_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic drain(input string name);
    int k;
    out_ready = 1'b1;
    for (k = 0; k < 500; k++) begin
      if (q.size() == 0 && !out_valid) break;
      step();
    end
    check(name, 64'(k < 500), 64'd1);
  endtask

  typedef struct {
    logic [63:0] x;
    logic [63:0] z;
    logic        inv;
  } vec_t;

  vec_t vt[8];
  int   lat;
  int   low;
  int   seen;
  int   base;

  initial begin
    vt[0] = '{64'h4010_0000_0000_0000, 64'h4000_0000_0000_0000, 1'b0};
    vt[1] = '{64'h3FF0_0000_0000_0000, 64'h3FF0_0000_0000_0000, 1'b0};
    vt[2] = '{64'h4022_0000_0000_0000, 64'h4008_0000_0000_0000, 1'b0};
    vt[3] = '{64'hBFF0_0000_0000_0000, 64'h0, 1'b1};
    vt[4] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0};
    vt[5] = '{64'h7FF8_0000_0000_0000, 64'h0, 1'b1};
    vt[6] = '{64'h7FF0_0000_0000_0000, 64'h7FF0_0000_0000_0000, 1'b0};
    vt[7] = '{64'h0, 64'h0, 1'b0};

    repeat (3) step();
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_sqrt_a", sqrt_a, 64'h0);
    rst_n = 1'b1;
    step();
    check("rel_in_ready", 64'(in_ready), 64'd1);

    // Directed vectors, one op at a time.
    foreach (vt[i]) begin
      single(vt[i].x, lat);
      check("latency", 64'(lat), 64'(LAT + 1));
      check("vec_inv", 64'(out_invalid), 64'(vt[i].inv));
      if (!vt[i].inv)
        check("vec_data", out_data, vt[i].z);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check("vec_popped", 64'(out_valid), 64'd0);
    end

    // 100 back-to-back ops with the consumer always ready.
    out_ready = 1'b1;
    pop_cyc.delete();
    low = 0;
    for (int i = 0; i < 100; i++) begin
      in_data  = rnd_pos();
      in_valid = 1'b1;
      if (!in_ready) low++;
      step();
    end
    in_valid = 1'b0;
    drain("burst_drain");
    check("burst_ready_low", 64'(low), 64'd0);
    check("burst_count", 64'(pop_cyc.size()), 64'd100);
    if (pop_cyc.size() == 100)
      check("burst_span", 64'(pop_cyc[99] - pop_cyc[0]), 64'd99);

    // Full backpressure: exactly DEPTH accepts.
    out_ready = 1'b0;
    base = accepts;
    for (int i = 0; i < 80; i++) begin
      in_data  = rnd_pos();
      in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    check("bp_accepts", 64'(accepts - base), 64'(DEPTH));
    check("bp_in_ready", 64'(in_ready), 64'd0);
    base = pops;
    drain("bp_drain");
    check("bp_pops", 64'(pops - base), 64'(DEPTH));

    // Random traffic against the scoreboard.
    for (int i = 0; i < 400; i++) begin
      in_data   = rnd_any();
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    in_valid = 1'b0;
    drain("rnd_drain");
    check("rnd_empty", 64'(q.size()), 64'd0);

    // Reset with 5 queued and 10 in flight.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_data  = rnd_pos();
      in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    repeat (30) step();
    check("pre_rst_queued", 64'(out_valid), 64'd1);
    for (int i = 0; i < 10; i++) begin
      in_data  = rnd_pos();
      in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    repeat (3) step();
    rst_n = 1'b0;
    step();
    step();
    check("mid_rst_in_ready", 64'(in_ready), 64'd0);
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (out_valid) seen++;
    end
    check("post_rst_quiet", 64'(seen), 64'd0);
    single(64'h3FF0_0000_0000_0000, lat);
    check("post_rst_lat", 64'(lat), 64'(LAT + 1));
    check("post_rst_data", out_data, 64'h3FF0_0000_0000_0000);
    check("post_rst_inv", 64'(out_invalid), 64'd0);
    drain("post_rst_drain");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
